// File: rtl/toggle_pkg.sv
// ---------------------------------------------------------------------------
// toggle_pkg
// Shared definitions for the toggle window controller: the FSM state type
// and its encodings, plus a small saturating-limit helper.
// ---------------------------------------------------------------------------
package toggle_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_COUNT = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Saturate a 32-bit sum to a counter of width cnt_w (cnt_w <= 31).
    function automatic logic [31:0] sat_limit(input logic [31:0] value, input int cnt_w);
        logic [31:0] max_v;
        max_v = (32'd1 << cnt_w) - 32'd1;
        return (value > max_v) ? max_v : value;
    endfunction

endpackage

// File: rtl/toggle_counter.sv
// ---------------------------------------------------------------------------
// toggle_counter
// One monitored net: previous-value register, edge detect and a saturating
// toggle counter.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clr          clear the counter (accepted start)
//   load         capture the net without counting (ARM cycle)
//   en           count toggles and track the net (COUNT cycles)
//   sig          monitored net
//   count        current toggle count
//   sat_hit      a toggle arrived while the counter was already saturated
// ---------------------------------------------------------------------------
module toggle_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic             en,
    input  logic             sig,
    output logic [CNT_W-1:0] count,
    output logic             sat_hit
);

    logic             sig_prev_r;
    logic [CNT_W-1:0] count_r;
    logic             toggle_s;
    logic             at_max_s;

    // Edge detect and saturation flag for the current cycle.
    always_comb begin
        toggle_s = sig ^ sig_prev_r;
        at_max_s = &count_r;
        sat_hit  = en & toggle_s & at_max_s;
    end

    // Previous-value register: loaded in ARM, followed every COUNT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_prev_r <= 1'b0;
        end else if (load || en) begin
            sig_prev_r <= sig;
        end else begin
            sig_prev_r <= sig_prev_r;
        end
    end

    // Saturating toggle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (en && toggle_s && !at_max_s) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/toggle_window_ctrl.sv
// ---------------------------------------------------------------------------
// toggle_window_ctrl
// Counts toggles on NUM_SIG nets over a programmable window, then drains the
// per-net counts through a valid/ready readout port.
// Sequence: IDLE -> ARM -> COUNT (win_len cycles) -> DRAIN -> DONE -> IDLE.
// Optional build macro TOGGLE_TOTAL_EN: DRAIN appends a word with
// idx = NUM_SIG carrying the saturated sum of all counts.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        begin a run (IDLE only); win_len captured at the same edge
//   sig_in       monitored nets
//   busy         high in every state but IDLE
//   out_valid    readout word valid (all DRAIN cycles)
//   out_ready    consumer accepts the word
//   out_idx      net index of the current word
//   out_count    toggle count of the current word
//   overflow     sticky: a counter (or the total) saturated in this run
//   done         one-cycle pulse after the final readout handshake
// ---------------------------------------------------------------------------
module toggle_window_ctrl
    import toggle_pkg::*;
#(
    parameter int NUM_SIG = 4,
    parameter int CNT_W   = 16,
    parameter int WIN_W   = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [WIN_W-1:0]               win_len,
    input  logic [NUM_SIG-1:0]             sig_in,
    output logic                           busy,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [$clog2(NUM_SIG+1)-1:0]   out_idx,
    output logic [CNT_W-1:0]               out_count,
    output logic                           overflow,
    output logic                           done
);

    localparam int IDX_W = $clog2(NUM_SIG + 1);
`ifdef TOGGLE_TOTAL_EN
    localparam int NUM_WORDS = NUM_SIG + 1;
`else
    localparam int NUM_WORDS = NUM_SIG;
`endif
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    state_t             state_r;
    state_t             state_nx;
    logic [WIN_W-1:0]   win_rem_r;
    logic [IDX_W-1:0]   idx_r;
    logic               overflow_r;
    logic               busy_r;
    logic               out_valid_r;
    logic               done_r;

    logic               start_acc_s;
    logic               handshake_s;
    logic               total_ovf_s;
    logic [CNT_W-1:0]   word_s;
    logic [CNT_W-1:0]   cnt_s [NUM_SIG];
    logic [NUM_SIG-1:0] sat_s;

    // Per-net edge detectors and counters.
    for (genvar g = 0; g < NUM_SIG; g++) begin : g_cnt
        toggle_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr     (start_acc_s),
            .load    (state_r == ST_ARM),
            .en      (state_r == ST_COUNT),
            .sig     (sig_in[g]),
            .count   (cnt_s[g]),
            .sat_hit (sat_s[g])
        );
    end

    // Run control qualifiers.
    always_comb begin
        start_acc_s = (state_r == ST_IDLE) && start;
        handshake_s = (state_r == ST_DRAIN) && out_ready;
    end

    // Readout word select; the total word (optional) follows the per-net words.
    always_comb begin
        word_s      = '0;
        total_ovf_s = 1'b0;
        for (int i = 0; i < NUM_SIG; i++) begin
            word_s = word_s | (cnt_s[i] & {CNT_W{idx_r == IDX_W'(i)}});
        end
`ifdef TOGGLE_TOTAL_EN
        begin : b_total
            logic [31:0] sum_v;
            sum_v = 32'd0;
            for (int i = 0; i < NUM_SIG; i++) begin
                sum_v = sum_v + 32'(cnt_s[i]);
            end
            total_ovf_s = (sum_v != sat_limit(sum_v, CNT_W));
            if (idx_r == IDX_W'(NUM_SIG)) begin
                word_s = CNT_W'(sat_limit(sum_v, CNT_W));
            end else begin
                word_s = word_s;
            end
        end
`endif
    end

    // Next-state logic.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nx = ST_ARM;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_ARM: begin
                // A zero-length window skips counting entirely.
                if (win_rem_r == WIN_W'(0)) begin
                    state_nx = ST_DRAIN;
                end else begin
                    state_nx = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (win_rem_r == WIN_W'(1)) begin
                    state_nx = ST_DRAIN;
                end else begin
                    state_nx = ST_COUNT;
                end
            end
            ST_DRAIN: begin
                if (handshake_s && (idx_r == LAST_IDX)) begin
                    state_nx = ST_DONE;
                end else begin
                    state_nx = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // State register and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nx;
            busy_r      <= (state_nx != ST_IDLE);
            out_valid_r <= (state_nx == ST_DRAIN);
            done_r      <= (state_nx == ST_DONE);
        end
    end

    // Remaining window cycles: captured on start so later win_len changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_rem_r <= '0;
        end else if (start_acc_s) begin
            win_rem_r <= win_len;
        end else if (state_r == ST_COUNT) begin
            win_rem_r <= win_rem_r - WIN_W'(1);
        end else begin
            win_rem_r <= win_rem_r;
        end
    end

    // Readout index: advances on handshake, returns to 0 after the last word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r <= '0;
        end else if (handshake_s) begin
            if (idx_r == LAST_IDX) begin
                idx_r <= '0;
            end else begin
                idx_r <= idx_r + IDX_W'(1);
            end
        end else begin
            idx_r <= idx_r;
        end
    end

    // Sticky overflow: cleared by an accepted start only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r <= 1'b0;
        end else if (start_acc_s) begin
            overflow_r <= 1'b0;
        end else if ((|sat_s) ||
                     (total_ovf_s && (state_r == ST_DRAIN) && (idx_r == IDX_W'(NUM_SIG)))) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign busy      = busy_r;
    assign out_valid = out_valid_r;
    assign out_idx   = idx_r;
    assign out_count = word_s;
    assign overflow  = overflow_r;
    assign done      = done_r;

endmodule

// File: tb/tb_toggle_window_ctrl.sv
// ---------------------------------------------------------------------------
// tb_toggle_window_ctrl
// Two instances share all inputs: a default one (CNT_W=16) and a narrow one
// (CNT_W=4) to exercise saturation. Table vectors carry hand-written expected
// counts; random runs use a reference model counting bit differences between
// successive sampled sig_in values.
// ---------------------------------------------------------------------------
module tb_toggle_window_ctrl;

    localparam int N  = 4;
`ifdef TOGGLE_TOTAL_EN
    localparam int NW  = N + 1;
    localparam bit TOT = 1'b1;
`else
    localparam int NW  = N;
    localparam bit TOT = 1'b0;
`endif
    localparam int MAX_A = 65535;
    localparam int MAX_B = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] win_len = 16'd0;
    logic [3:0]  sig_in = 4'd0;
    logic        out_ready = 1'b0;

    logic        a_busy, a_valid, a_ovf, a_done;
    logic [2:0]  a_idx;
    logic [15:0] a_count;
    logic        b_busy, b_valid, b_ovf, b_done;
    logic [2:0]  b_idx;
    logic [3:0]  b_count;

    int n_vec = 0;
    int n_err = 0;
    logic [3:0] seq [0:63];

    toggle_window_ctrl dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .win_len(win_len), .sig_in(sig_in),
        .busy(a_busy), .out_valid(a_valid), .out_ready(out_ready), .out_idx(a_idx),
        .out_count(a_count), .overflow(a_ovf), .done(a_done)
    );

    toggle_window_ctrl #(.CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .win_len(win_len), .sig_in(sig_in),
        .busy(b_busy), .out_valid(b_valid), .out_ready(out_ready), .out_idx(b_idx),
        .out_count(b_count), .overflow(b_ovf), .done(b_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]       win;
        logic [3:0][7:0]  tog;
        logic [2:0]       st_idx;
        logic [3:0]       st_len;
        logic [3:0][15:0] exp_a;
        logic             ovf_a;
        logic [3:0][15:0] exp_b;
        logic             ovf_b;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0][15:0] pk(input int c0, input int c1, input int c2, input int c3);
        logic [3:0][15:0] r;
        r[0] = 16'(c0); r[1] = 16'(c1); r[2] = 16'(c2); r[3] = 16'(c3);
        return r;
    endfunction

    function automatic logic [3:0][7:0] pt(input int c0, input int c1, input int c2, input int c3);
        logic [3:0][7:0] r;
        r[0] = 8'(c0); r[1] = 8'(c1); r[2] = 8'(c2); r[3] = 8'(c3);
        return r;
    endfunction

    // Checks all outputs of both instances against the reset values.
    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, {a_busy, b_busy}, 2'b00);
        chk({tag, "_valid"}, {a_valid, b_valid}, 2'b00);
        chk({tag, "_idx"}, {a_idx, b_idx}, 6'd0);
        chk({tag, "_count_a"}, a_count, 16'd0);
        chk({tag, "_count_b"}, b_count, 4'd0);
        chk({tag, "_ovf"}, {a_ovf, b_ovf}, 2'b00);
        chk({tag, "_done"}, {a_done, b_done}, 2'b00);
    endtask

    // One complete run; seq[0..w] must be filled, seq[0] is the ARM sample.
    task automatic run_meas(input int w, input int st_idx, input int st_len,
                            input logic [3:0][15:0] ea, input logic ova,
                            input logic [3:0][15:0] eb, input logic ovb);
        int suma, sumb, ta, tb;
        logic fa, fb;
        int xa, xb;
        suma = 0; sumb = 0;
        for (int i = 0; i < N; i++) begin
            suma += int'(ea[i]);
            sumb += int'(eb[i]);
        end
        ta = (suma > MAX_A) ? MAX_A : suma;
        tb = (sumb > MAX_B) ? MAX_B : sumb;
        fa = ova | (TOT & (suma > MAX_A));
        fb = ovb | (TOT & (sumb > MAX_B));

        @(negedge clk);
        start = 1'b1; win_len = 16'(w); sig_in = 4'($urandom);
        @(negedge clk);
        chk("arm_busy", {a_busy, b_busy}, 2'b11);
        chk("arm_valid", a_valid, 1'b0);
        start = 1'b0; sig_in = seq[0];
        @(negedge clk);
        chk("arm_exit_valid", a_valid, (w == 0));
        for (int k = 1; k <= w; k++) begin
            sig_in  = seq[k];
            start   = 1'($urandom);
            win_len = 16'($urandom);
            @(negedge clk);
            chk("count_valid", {a_valid, b_valid}, (k == w) ? 2'b11 : 2'b00);
            chk("count_busy", a_busy, 1'b1);
        end
        start = 1'b0;
        chk("drain_ovf_a", a_ovf, ova);
        chk("drain_ovf_b", b_ovf, ovb);
        for (int j = 0; j < NW; j++) begin
            xa = (j < N) ? int'(ea[j]) : ta;
            xb = (j < N) ? int'(eb[j]) : tb;
            out_ready = 1'b0;
            for (int s = 0; s < ((j == st_idx) ? st_len : 0); s++) begin
                chk("stall_idx", a_idx, j);
                chk("stall_count", a_count, xa);
                chk("stall_valid", a_valid, 1'b1);
                @(negedge clk);
            end
            chk("word_idx", {a_idx, b_idx}, {3'(j), 3'(j)});
            chk("word_count_a", a_count, xa);
            chk("word_count_b", b_count, xb);
            chk("word_valid", a_valid, 1'b1);
            chk("word_done", a_done, 1'b0);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        chk("done_pulse", {a_done, b_done}, 2'b11);
        chk("done_valid", a_valid, 1'b0);
        chk("done_busy", a_busy, 1'b1);
        chk("done_ovf_a", a_ovf, fa);
        chk("done_ovf_b", b_ovf, fb);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("post_done", {a_done, b_done}, 2'b00);
        chk("post_busy", {a_busy, b_busy}, 2'b00);
        chk("idle_idx", a_idx, 3'd0);
        chk("idle_count_a", a_count, ea[0]);
        chk("idle_count_b", b_count, eb[0]);
        chk("idle_ovf", {a_ovf, b_ovf}, {fa, fb});
    endtask

    // Builds seq from a table entry: bit i toggles in COUNT cycles 1..tog[i].
    task automatic build_seq(input vec_t v);
        seq[0] = 4'($urandom);
        for (int k = 1; k <= int'(v.win); k++) begin
            for (int i = 0; i < N; i++) begin
                seq[k][i] = seq[k-1][i] ^ (k <= int'(v.tog[i]));
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        build_seq(v);
        run_meas(int'(v.win), int'(v.st_idx), int'(v.st_len), v.exp_a, v.ovf_a, v.exp_b, v.ovf_b);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, raw;
        logic [3:0][15:0] ea, eb;
        logic ova, ovb;

        tbl[0] = '{win: 8'd8,  tog: pt(8, 0, 0, 0),     st_idx: 3'd7, st_len: 4'd0,
                   exp_a: pk(8, 0, 0, 0), ovf_a: 1'b0, exp_b: pk(8, 0, 0, 0), ovf_b: 1'b0};
        tbl[1] = '{win: 8'd0,  tog: pt(0, 0, 0, 0),     st_idx: 3'd7, st_len: 4'd0,
                   exp_a: pk(0, 0, 0, 0), ovf_a: 1'b0, exp_b: pk(0, 0, 0, 0), ovf_b: 1'b0};
        tbl[2] = '{win: 8'd20, tog: pt(0, 20, 0, 0),    st_idx: 3'd7, st_len: 4'd0,
                   exp_a: pk(0, 20, 0, 0), ovf_a: 1'b0, exp_b: pk(0, 15, 0, 0), ovf_b: 1'b1};
        tbl[3] = '{win: 8'd5,  tog: pt(0, 5, 0, 5),     st_idx: 3'd2, st_len: 4'd5,
                   exp_a: pk(0, 5, 0, 5), ovf_a: 1'b0, exp_b: pk(0, 5, 0, 5), ovf_b: 1'b0};
        tbl[4] = '{win: 8'd4,  tog: pt(3, 1, 0, 2),     st_idx: 3'd4, st_len: 4'd3,
                   exp_a: pk(3, 1, 0, 2), ovf_a: 1'b0, exp_b: pk(3, 1, 0, 2), ovf_b: 1'b0};
        tbl[5] = '{win: 8'd30, tog: pt(30, 30, 30, 30), st_idx: 3'd0, st_len: 4'd2,
                   exp_a: pk(30, 30, 30, 30), ovf_a: 1'b0, exp_b: pk(15, 15, 15, 15), ovf_b: 1'b1};

        // Reset state.
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_vals("post_reset");

        // Table vectors.
        for (int t = 0; t < 6; t++) begin
            run_vec(tbl[t]);
        end

        // Reset in the third COUNT cycle aborts the run without done.
        build_seq(tbl[5]);
        @(negedge clk);
        start = 1'b1; win_len = 16'd10;
        @(negedge clk);
        start = 1'b0; sig_in = seq[0];
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            sig_in = seq[k];
        end
        chk("pre_abort_busy", a_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("abort");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort_idle", {a_busy, a_done, b_busy, b_done}, 4'b0000);
        end
        run_vec(tbl[0]);

        // Random windows checked against the toggle-counting model.
        for (int r = 0; r < 16; r++) begin
            w = $urandom_range(0, 40);
            seq[0] = 4'($urandom);
            for (int k = 1; k <= w; k++) begin
                seq[k] = ($urandom_range(0, 1) == 0) ? seq[k-1] : 4'($urandom);
            end
            ova = 1'b0; ovb = 1'b0;
            for (int i = 0; i < N; i++) begin
                raw = 0;
                for (int k = 1; k <= w; k++) begin
                    if (seq[k][i] != seq[k-1][i]) raw++;
                end
                ea[i] = 16'((raw > MAX_A) ? MAX_A : raw);
                eb[i] = 16'((raw > MAX_B) ? MAX_B : raw);
                ova |= (raw > MAX_A);
                ovb |= (raw > MAX_B);
            end
            run_meas(w, $urandom_range(0, NW - 1), $urandom_range(0, 3), ea, ova, eb, ovb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/toggle_window_ctrl.md
TOGGLE_WINDOW_CTRL -- requirements
Module: toggle_window_ctrl

Interface
REQ-001 SHALL have parameter NUM_SIG, default 4: number of monitored nets.
REQ-002 SHALL have parameter CNT_W, default 16: per-net toggle counter width.
REQ-003 SHALL have parameter WIN_W, default 16: measurement window length width.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port start  input  1: begin measurement; sampled only in IDLE.
REQ-007 SHALL have port win_len  input  WIN_W: window length in cycles; captured on accepted start.
REQ-008 SHALL have port sig_in  input  NUM_SIG: monitored nets, e.g. DFF-under-test D/Q/Q_bar.
REQ-009 SHALL have port busy  output  1: high in every state except IDLE.
REQ-010 SHALL have port out_valid  output  1: readout word valid.
REQ-011 SHALL have port out_ready  input  1: consumer accepts the word when out_valid && out_ready.
REQ-012 SHALL have port out_idx  output  clog2(NUM_SIG+1): net index of the current word.
REQ-013 SHALL have port out_count  output  CNT_W: toggle count of the current word.
REQ-014 SHALL have port overflow  output  1: sticky; some counter saturated in this run.
REQ-015 SHALL have port done  output  1: one-cycle pulse after the final readout handshake.

Function
REQ-016 SHALL implement FSM IDLE -> ARM -> COUNT -> DRAIN -> DONE -> IDLE.
REQ-017 IDLE: start=1 SHALL capture win_len and clear all counters and overflow; next state ARM.
REQ-018 ARM (1 cycle): SHALL load sig_prev <= sig_in with no counting; next state COUNT, or DRAIN if captured win_len == 0.
REQ-019 COUNT SHALL last exactly win_len cycles; each cycle, for each i where sig_in[i] != sig_prev[i], cnt[i] increments by 1; sig_prev <= sig_in every cycle.
REQ-020 Counters SHALL saturate at 2^CNT_W-1; an increment attempt at saturation SHALL set overflow.
REQ-021 DRAIN SHALL present words in order idx 0..NUM_SIG-1, holding out_idx/out_count stable while out_valid && !out_ready.
REQ-022 out_valid SHALL be high for every DRAIN cycle and low in all other states; idx advances only on handshake.
REQ-023 Handshake on the last word SHALL move to DONE; done=1 for exactly that cycle; then IDLE.
REQ-024 start SHALL be ignored outside IDLE; a start asserted in the DONE cycle is not accepted.
REQ-025 Changes to win_len after capture SHALL have no effect on the running window.
REQ-026 Counts and overflow SHALL remain readable (unchanged) in IDLE until the next accepted start.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, counters=0, sig_prev=0, overflow=0, busy=0, out_valid=0, out_idx=0, out_count=0, done=0.
REQ-028 Reset mid-COUNT or mid-DRAIN SHALL abort the run with no done pulse; a new start is required after release.

Configuration
REQ-029 Macro TOGGLE_TOTAL_EN defined: DRAIN SHALL emit one extra word, idx=NUM_SIG, count = sum of all cnt[i], saturating at 2^CNT_W-1 (saturation sets overflow); done follows that word's handshake.
REQ-030 Macro TOGGLE_TOTAL_EN undefined: DRAIN SHALL emit exactly NUM_SIG words and no adder SHALL be built.

Structure
REQ-031 Package toggle_pkg SHALL hold the state enum type and the FSM state encodings.
REQ-032 Sub-module toggle_counter (edge detect + saturating counter + clear/enable) SHALL be instantiated NUM_SIG times.

Verification
REQ-033 win_len=8, sig_in[0] toggling every cycle, others static, out_ready=1 -> counts {8,0,0,0}, done 1 cycle after idx 3 handshake.
REQ-034 win_len=0 -> ARM then DRAIN directly; all counts 0; overflow=0.
REQ-035 CNT_W=4, win_len=20, sig_in[1] toggling every cycle -> cnt[1]=15, overflow=1.
REQ-036 out_ready held low 5 cycles on idx 2 -> out_idx/out_count stable, no advance; start pulses during COUNT ignored.
REQ-037 rst_n pulsed low during COUNT cycle 3 -> outputs at reset values at once, no done; next start runs normally.
REQ-038 TOGGLE_TOTAL_EN, counts {3,1,0,2} -> fifth word idx=4, count=6.
